dff_share_arbiter: RTL and testbench

//   Round-robin arbiter that shares one flop-based data register among
//   NUM_REQ requesters. Granted requester writes its din into the shared

---
 rtl/dff_share_pkg.sv | 16 +
 rtl/dff_rr_pick.sv | 36 +++
 rtl/dff_share_arbiter.sv | 132 +++++++++++++
 tb/tb_dff_share_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dff_share_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package dff_share_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int DEFAULT_NUM_REQ = 4;

  // Width of an index or counter covering n values; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_rr_pick.sv
// Combinational round-robin priority encoder: first set (req & mask) bit at or after ptr, wrapping.
module dff_rr_pick
  import dff_share_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_index
);

  logic [NUM_REQ-1:0] w_cand;

  assign w_cand = i_req & i_mask;

  // Scan from the farthest offset down so the nearest candidate to ptr is assigned last.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int               pos;
      logic [IDX_W-1:0] idx;
      pos = int'(i_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = IDX_W'(pos);
      if (w_cand[idx]) begin
        o_valid = 1'b1;
        o_index = idx;
      end
    end
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one flop data register among NUM_REQ writers,
// with lock-driven bursts capped at MAX_BURST consecutive writes.
module dff_share_arbiter
  import dff_share_pkg::*;
#(
  parameter  int                NUM_REQ   = DEFAULT_NUM_REQ,
  parameter  int                DATA_W    = 8,
  parameter  int                MAX_BURST = 4,
  parameter  logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b1}},
  localparam int                IDX_W     = idx_width(NUM_REQ),
  localparam int                CNT_W     = idx_width(MAX_BURST)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [IDX_W-1:0]          owner_id,
  output logic                      busy,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid
);

  arb_state_e          r_state, w_state_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]    r_owner, w_owner_nxt;
  logic [IDX_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]    r_burst_cnt, w_burst_cnt_nxt;
  logic [DATA_W-1:0]   r_dout, w_dout_nxt;
  logic                r_dout_valid, w_dout_valid_nxt;

  logic [DATA_W-1:0]   w_din_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  w_owner_oh, w_pick_oh, w_pick_mask;
  logic [IDX_W-1:0]    w_after_owner, w_pick_ptr, w_pick_idx;
  logic                w_pick_valid, w_write, w_release;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_din
    assign w_din_arr[g] = din[g*DATA_W +: DATA_W];
  end

  assign w_owner_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_pick_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_after_owner = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  assign w_write   = (r_state == OWN) && ((r_gnt & req) != '0);
  assign w_release = (r_state == OWN) &&
                     (!req[r_owner] || !lock[r_owner] ||
                      (r_burst_cnt == CNT_W'(MAX_BURST - 1)));

  // While owned, the handover search starts past the owner and excludes it.
  assign w_pick_ptr  = (r_state == OWN) ? w_after_owner : r_rr_ptr;
  assign w_pick_mask = (r_state == OWN) ? ~w_owner_oh : '1;

  dff_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req   (req),
    .i_mask  (w_pick_mask),
    .i_ptr   (w_pick_ptr),
    .o_valid (w_pick_valid),
    .o_index (w_pick_idx)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_gnt_nxt        = r_gnt;
    w_owner_nxt      = r_owner;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_burst_cnt_nxt  = r_burst_cnt;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = OWN;
          w_gnt_nxt   = w_pick_oh;
          w_owner_nxt = w_pick_idx;
        end
      end
      OWN: begin
        if (w_write) begin
          w_dout_nxt       = w_din_arr[r_owner];
          w_dout_valid_nxt = 1'b1;
          w_burst_cnt_nxt  = r_burst_cnt + CNT_W'(1);
        end
        if (w_release) begin
          w_rr_ptr_nxt    = w_after_owner;
          w_burst_cnt_nxt = '0;
          if (w_pick_valid) begin
            w_gnt_nxt   = w_pick_oh;
            w_owner_nxt = w_pick_idx;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_burst_cnt  <= '0;
      r_dout       <= RESET_VAL;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_owner      <= w_owner_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign owner_id   = r_owner;
  assign busy       = (r_state == OWN);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Scoreboard bench for dff_share_arbiter: directed scenarios plus random traffic vs a behavioural model.
module tb_dff_share_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MAXB = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [N*DW-1:0] din;
  logic [N-1:0]  gnt;
  logic [1:0]    owner_id;
  logic          busy;
  logic [DW-1:0] dout;
  logic          dout_valid;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [1:0]    owner;
    logic          busy;
    logic [DW-1:0] dout;
    logic          valid;
  } exp_t;

  exp_t expQ[$];

  int checkCount = 0;
  int passCount  = 0;

  bit            mOwn;
  int            mOwner;
  int            mPtr;
  int            mWrites;
  logic [DW-1:0] mDout;
  bit            mValid;

  dff_share_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MAXB),
    .RESET_VAL (8'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lock       (lock),
    .din        (din),
    .gnt        (gnt),
    .owner_id   (owner_id),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First requester at or after 'start' (wrapping) that is not 'skip'; -1 if none.
  function automatic int findNext(input logic [N-1:0] r, input int start, input int skip);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (c != skip && r[c]) return c;
    end
    return -1;
  endfunction

  task automatic modelStep();
    mValid = 1'b0;
    if (!rst) begin
      mOwn = 1'b0; mOwner = 0; mPtr = 0; mWrites = 0; mDout = 8'hFF;
    end else if (!mOwn) begin
      int p;
      p = findNext(req, mPtr, -1);
      if (p >= 0) begin
        mOwn = 1'b1; mOwner = p;
      end
    end else begin
      bit wrote;
      bit done;
      wrote = req[mOwner];
      if (wrote) begin
        mDout = din[mOwner*DW +: DW];
        mValid = 1'b1;
        mWrites++;
      end
      done = !wrote || !lock[mOwner] || (mWrites == MAXB);
      if (done) begin
        int p;
        mPtr = (mOwner + 1) % N;
        mWrites = 0;
        p = findNext(req, mPtr, mOwner);
        if (p >= 0) mOwner = p;
        else mOwn = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] rq,
                               input logic [N-1:0] lk, input logic [N*DW-1:0] d);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; lock = lk; din = d;
    modelStep();
    e.gnt   = mOwn ? (4'b0001 << mOwner) : 4'b0000;
    e.owner = 2'(mOwner);
    e.busy  = mOwn;
    e.dout  = mDout;
    e.valid = mValid;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checkCount++;
    if (gnt === e.gnt && owner_id === e.owner && busy === e.busy &&
        dout === e.dout && dout_valid === e.valid) begin
      passCount++;
    end else begin
      $display("[TB] FAIL cycle t=%0t actual gnt=%b owner=%0d busy=%b dout=%h valid=%b required gnt=%b owner=%0d busy=%b dout=%h valid=%b",
               $time, gnt, owner_id, busy, dout, dout_valid,
               e.gnt, e.owner, e.busy, e.dout, e.valid);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    rst = 1'b0; req = '0; lock = '0; din = '0;
    mOwn = 1'b0; mOwner = 0; mPtr = 0; mWrites = 0; mDout = 8'hFF; mValid = 1'b0;

    // Reset held with every requester asking.
    applyStimulus(1'b0, 4'hF, 4'h0, 32'h44332211);
    applyStimulus(1'b0, 4'hF, 4'h0, 32'h44332211);
    applyStimulus(1'b1, 4'h0, 4'h0, 32'h0);

    // Single write from requester 1.
    applyStimulus(1'b1, 4'b0010, 4'h0, 32'h0000A500);
    applyStimulus(1'b1, 4'b0010, 4'h0, 32'h0000A500);
    repeat (3) applyStimulus(1'b1, 4'h0, 4'h0, 32'h0);

    // Round-robin rotation from a freshly reset pointer.
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0);
    repeat (6) applyStimulus(1'b1, 4'hF, 4'h0, 32'h44332211);
    repeat (2) applyStimulus(1'b1, 4'h0, 4'h0, 32'h0);

    // Burst capped at MAX_BURST writes, then handover to requester 2.
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 4'b0101, 4'b0001, {8'h00, 8'hC0 + 8'(i), 8'h00, 8'h10 + 8'(i)});
    repeat (2) applyStimulus(1'b1, 4'h0, 4'h0, 32'h0);

    // Owner drops req mid-burst with requester 3 waiting.
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 4'b1001, 4'b0001, {8'h3C, 16'h0, 8'h50 + 8'(i)});
    repeat (3) applyStimulus(1'b1, 4'b1000, 4'h0, 32'h3D000000);
    repeat (2) applyStimulus(1'b1, 4'h0, 4'h0, 32'h0);

    // Reset during a locked burst by requester 2, then all request.
    repeat (3) applyStimulus(1'b1, 4'b0100, 4'b0100, 32'h00770000);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 32'h00780000);
    repeat (5) applyStimulus(1'b1, 4'hF, 4'h0, 32'hDDCCBBAA);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 49) != 0), 4'($urandom), 4'($urandom), $urandom);

    @(posedge clk);
    #3;
    checkCount++;
    if (expQ.size() == 0) passCount++;
    else $display("[TB] FAIL scoreboard-drain actual=%0d pending required=0", expQ.size());

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
